posit_divider: RTL and testbench



---
 rtl/posit_pkg.sv | 33 +++
 rtl/posit_field_decode.sv | 53 +++++
 rtl/posit_divider.sv | 236 +++++++++++++++++++++++
 tb/tb_posit_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions: special-value words, scale sizing and the divider FSM encoding.
// Used by posit_field_decode and posit_divider.
package posit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StDivide,
    StRound,
    StDone
  } div_state_e;

  localparam logic [63:0] MinposWord = 64'd1;

  // Callers truncate these to n bits.
  function automatic logic [63:0] nar_word(int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] maxpos_word(int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic int unsigned max_scale(int unsigned n, int unsigned es);
    return (n - 2) * (2 ** es);
  endfunction

  // Signed width holding a scale difference of +/-2*maxscale plus normalisation.
  function automatic int unsigned scale_w(int unsigned n, int unsigned es);
    return $clog2(2 * (n - 2) * (2 ** es) + 2) + 1;
  endfunction

endpackage

// File: rtl/posit_field_decode.sv
// Combinational posit field decoder: sign, zero/NaR flags, scale k*2^ES+e and mantissa
// in [1,2) with N-1 fraction bits.
module posit_field_decode
  import posit_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned ES = 3,
  parameter int unsigned SW = scale_w(N, ES)
) (
  input  logic [N-1:0]         p_i,
  output logic                 sign_o,
  output logic                 is_zero_o,
  output logic                 is_nar_o,
  output logic signed [SW-1:0] scale_o,
  output logic [N-1:0]         mant_o
);

  localparam logic [N-1:0] Nar = N'(nar_word(N));

  logic [N-2:0] mag;
  logic [N-2:0] rem;
  logic [N-2:0] frac;
  logic         r0;
  logic         stop;
  int           run;
  int           k_i;
  int           e_i;

  always_comb begin
    sign_o    = p_i[N-1];
    is_zero_o = (p_i == '0);
    is_nar_o  = (p_i == Nar);
    mag       = p_i[N-1] ? (N-1)'(-p_i) : p_i[N-2:0];
    r0        = mag[N-2];
    run       = 0;
    stop      = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (mag[i] == r0)) begin
        run = run + 1;
      end else begin
        stop = 1'b1;
      end
    end
    k_i     = r0 ? (run - 1) : -run;
    // Drop the regime run and its terminator; exponent then sits at the top.
    rem     = mag << (run + 1);
    e_i     = int'(rem >> (N - 1 - ES));
    frac    = rem << ES;
    scale_o = SW'((k_i <<< ES) + e_i);
    mant_o  = {1'b1, frac};
  end

endmodule

// File: rtl/posit_divider.sv
// Multi-cycle posit divider (x / y) with valid/ready handshake; one quotient bit per cycle.
// Optional POSIT_DIVIDER_FLAGS_EN adds flags[1:0] = {inexact, divide-by-zero}.
module posit_divider
  import posit_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned ES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] posit
`ifdef POSIT_DIVIDER_FLAGS_EN
  ,
  output logic [1:0]   flags
`endif
);

  localparam int unsigned SW   = scale_w(N, ES);
  localparam int unsigned CntW = $clog2(N);
  localparam int unsigned TW   = ES + N - 1;
  localparam int unsigned WW   = N + TW;
  localparam logic [N-1:0] Nar = N'(nar_word(N));
  localparam logic [N-2:0] MaxMag = (N-1)'(maxpos_word(N));
  localparam logic [N-2:0] MinMag = (N-1)'(MinposWord);
  localparam logic signed [SW-1:0] MaxScale = SW'(max_scale(N, ES));

  div_state_e           state_q, state_d;
  logic [N-1:0]         x_q, x_d, y_q, y_d;
  logic                 sign_q, sign_d, nar_q, nar_d, zero_q, zero_d;
  logic signed [SW-1:0] scale_q, scale_d;
  logic [N-1:0]         my_q, my_d, quo_q, quo_d, posit_q, posit_d;
  logic [N:0]           rem_q, rem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
`ifdef POSIT_DIVIDER_FLAGS_EN
  logic                 dz_q, dz_d, inexact;
  logic [1:0]           flags_q, flags_d;
`endif

  logic                 sx, zx, nx, sy, zy, ny;
  logic signed [SW-1:0] sfx, sfy;
  logic [N-1:0]         mx, my;

  posit_field_decode #(.N(N), .ES(ES), .SW(SW)) u_dec_x (
    .p_i      (x_q),
    .sign_o   (sx),
    .is_zero_o(zx),
    .is_nar_o (nx),
    .scale_o  (sfx),
    .mant_o   (mx)
  );

  posit_field_decode #(.N(N), .ES(ES), .SW(SW)) u_dec_y (
    .p_i      (y_q),
    .sign_o   (sy),
    .is_zero_o(zy),
    .is_nar_o (ny),
    .scale_o  (sfy),
    .mant_o   (my)
  );

  // Restoring division step.
  logic [N:0] my_ext, rem_sub;
  logic       ge;
  assign my_ext  = {1'b0, my_q};
  assign ge      = (rem_q >= my_ext);
  assign rem_sub = ge ? (rem_q - my_ext) : rem_q;

  // Normalise, encode regime/exponent/fraction, round to nearest even, saturate.
  logic signed [SW-1:0] s_n;
  logic [N-2:0]         frac_n, mag, mag_rnd;
  logic [TW-1:0]        tail;
  logic [WW-1:0]        reg_v, enc_v;
  logic                 guard, sticky, round_up, sat_hi, sat_lo;
  logic [N-1:0]         rnd_posit;
  int                   k;

  always_comb begin
    if (quo_q[N-1]) begin
      s_n    = scale_q;
      frac_n = quo_q[N-2:0];
    end else begin
      s_n    = scale_q - SW'(1);
      frac_n = {quo_q[N-3:0], 1'b0};
    end
    sat_hi = (s_n > MaxScale);
    sat_lo = (s_n < -MaxScale);
    // Low ES bits of the scale are the exponent field.
    tail   = TW'({s_n, frac_n});
    k      = int'(s_n >>> ES);
    if (k >= 0) begin
      reg_v = ~({WW{1'b1}} >> (k + 1));
      enc_v = reg_v | ({tail, {N{1'b0}}} >> (k + 2));
    end else begin
      reg_v = {1'b1, {(WW-1){1'b0}}} >> (-k);
      enc_v = reg_v | ({tail, {N{1'b0}}} >> (1 - k));
    end
    mag      = enc_v[WW-1 -: N-1];
    guard    = enc_v[WW-N];
    sticky   = (|enc_v[WW-N-1:0]) | (|rem_q);
    round_up = guard & (sticky | mag[0]);
    mag_rnd  = (round_up && (mag != MaxMag)) ? mag + (N-1)'(1) : mag;
    if (sat_hi) begin
      mag_rnd = MaxMag;
    end else if (sat_lo) begin
      mag_rnd = MinMag;
    end
    if (nar_q) begin
      rnd_posit = Nar;
    end else if (zero_q) begin
      rnd_posit = '0;
    end else if (sign_q) begin
      rnd_posit = -{1'b0, mag_rnd};
    end else begin
      rnd_posit = {1'b0, mag_rnd};
    end
  end

`ifdef POSIT_DIVIDER_FLAGS_EN
  assign inexact = ~(nar_q | zero_q) & (sat_hi | sat_lo | guard | sticky);
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sign_d  = sign_q;
    nar_d   = nar_q;
    zero_d  = zero_q;
    scale_d = scale_q;
    my_d    = my_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    posit_d = posit_q;
`ifdef POSIT_DIVIDER_FLAGS_EN
    dz_d    = dz_q;
    flags_d = flags_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          state_d = StDecode;
        end
      end
      StDecode: begin
        sign_d  = sx ^ sy;
        nar_d   = nx | ny | zy;
        zero_d  = zx;
        scale_d = sfx - sfy;
        my_d    = my;
        rem_d   = {1'b0, mx};
        quo_d   = '0;
        cnt_d   = '0;
`ifdef POSIT_DIVIDER_FLAGS_EN
        dz_d    = zy & ~nx;
`endif
        state_d = StDivide;
      end
      StDivide: begin
        rem_d = rem_sub << 1;
        quo_d = {quo_q[N-2:0], ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StRound;
        end
      end
      StRound: begin
        posit_d = rnd_posit;
`ifdef POSIT_DIVIDER_FLAGS_EN
        flags_d = {inexact, dz_q};
`endif
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      sign_q  <= 1'b0;
      nar_q   <= 1'b0;
      zero_q  <= 1'b0;
      scale_q <= '0;
      my_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      posit_q <= '0;
`ifdef POSIT_DIVIDER_FLAGS_EN
      dz_q    <= 1'b0;
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sign_q  <= sign_d;
      nar_q   <= nar_d;
      zero_q  <= zero_d;
      scale_q <= scale_d;
      my_q    <= my_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      posit_q <= posit_d;
`ifdef POSIT_DIVIDER_FLAGS_EN
      dz_q    <= dz_d;
      flags_q <= flags_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign posit     = posit_q;
`ifdef POSIT_DIVIDER_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_posit_divider.sv
// Directed bench for posit_divider (N=16, ES=3): vector table, backpressure and mid-op reset.
module tb_posit_divider;

  localparam int unsigned N   = 16;
  localparam int unsigned ES  = 3;
  // Cycles from the accept cycle (counted as cycle 1) to the first cycle with out_valid high.
  localparam int          Lat = N + 3;
  localparam int          NumVec = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  x, y, posit;
`ifdef POSIT_DIVIDER_FLAGS_EN
  logic [1:0]    flags;
`endif

  posit_divider #(.N(N), .ES(ES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .posit    (posit)
`ifdef POSIT_DIVIDER_FLAGS_EN
    ,
    .flags    (flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] q;
    logic [1:0]  f;
  } vec_t;

  vec_t vecs[NumVec];
  int   nvec = 0;
  int   nmis = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Presents one operand pair from IDLE and waits (bounded) for the result.
  task automatic run_op(input logic [15:0] xi, input logic [15:0] yi,
                        output logic [15:0] q, output logic [1:0] f, output int cycles);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    x        = xi;
    y        = yi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cycles   = 1;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    q = posit;
`ifdef POSIT_DIVIDER_FLAGS_EN
    f = flags;
`else
    f = 2'b00;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] q;
    logic [1:0]  f;
    int          cyc;
    logic        stale;

    vecs[0]  = '{16'h4400, 16'h4000, 16'h4400, 2'b00};
    vecs[1]  = '{16'h4000, 16'h4400, 16'h3C00, 2'b00};
    vecs[2]  = '{16'h4600, 16'h4400, 16'h4200, 2'b00};
    vecs[3]  = '{16'h4000, 16'hC000, 16'hC000, 2'b00};
    vecs[4]  = '{16'h4000, 16'h0000, 16'h8000, 2'b01};
    vecs[5]  = '{16'h0000, 16'h6AD5, 16'h0000, 2'b00};
    vecs[6]  = '{16'h8000, 16'h4000, 16'h8000, 2'b00};
    vecs[7]  = '{16'h7FFF, 16'h0001, 16'h7FFF, 2'b10};
    vecs[8]  = '{16'h0001, 16'h7FFF, 16'h0001, 2'b10};
    vecs[9]  = '{16'h4000, 16'h4000, 16'h4000, 2'b00};
    vecs[10] = '{16'hC000, 16'hC000, 16'h4000, 2'b00};
    vecs[11] = '{16'h4000, 16'h4600, 16'h3955, 2'b10};
    vecs[12] = '{16'h4600, 16'h4000, 16'h4600, 2'b00};

    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_posit", {16'd0, posit}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NumVec; i++) begin
      run_op(vecs[i].x, vecs[i].y, q, f, cyc);
      check($sformatf("vec%0d_posit", i), {16'd0, q}, {16'd0, vecs[i].q});
      check($sformatf("vec%0d_latency", i), cyc, Lat);
`ifdef POSIT_DIVIDER_FLAGS_EN
      check($sformatf("vec%0d_flags", i), {30'd0, f}, {30'd0, vecs[i].f});
`endif
    end

    // Backpressure: result held, new operands ignored while DONE.
    out_ready = 1'b0;
    x         = 16'h4600;
    y         = 16'h4400;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc      = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_latency", cyc, Lat);
    x        = 16'h4000;
    y        = 16'h0000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_posit", {16'd0, posit}, 32'h4200);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 1'b0;
    repeat (N + 5) begin
      @(posedge clk);
      #1;
      stale |= out_valid;
    end
    check("bp_no_ghost_op", {31'd0, stale}, 32'd0);

    // Reset five cycles into DIVIDE.
    x        = 16'h4000;
    y        = 16'h4400;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_posit", {16'd0, posit}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    stale = 1'b0;
    repeat (N + 5) begin
      @(posedge clk);
      #1;
      stale |= out_valid;
    end
    check("mid_rst_no_stale", {31'd0, stale}, 32'd0);
    run_op(16'h4000, 16'h4000, q, f, cyc);
    check("post_rst_posit", {16'd0, q}, 32'h4000);
    check("post_rst_latency", cyc, Lat);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
